// File: rtl/mips_pkg.sv
// Shared fetch-stage types and instruction field constants.
package mips_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_START,
    ST_REQ,
    ST_WAIT,
    ST_DROP
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID holding register: load a fetched word, drain on decode
// handshake, flush on redirect.
import mips_pkg::*;

module if_id_reg #(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_flush,
  input  logic               i_drain,
  input  logic [INSTR_W-1:0] i_inst,
  input  logic [ADDR_W-1:0]  i_pc4,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_inst,
  output logic [ADDR_W-1:0]  o_pc4
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_inst;
  logic [ADDR_W-1:0]  r_pc4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_inst  <= '0;
      r_pc4   <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_inst  <= i_inst;
      r_pc4   <= i_pc4;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS fetch stage: PC, single-outstanding imem request FSM,
// redirect flush and IF/ID register.
import mips_pkg::*;

module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_rsp_valid,
  input  logic [INSTR_W-1:0]  imem_rsp_data,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [INSTR_W-1:0]  id_inst,
  output logic [ADDR_W-1:0]   id_pc4,
  output logic [OPCODE_W-1:0] id_opcode
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_pc4;
  logic              w_slot_free;
  logic              w_req;
  logic              w_load;
  logic              w_flush;

  assign w_pc4       = r_pc + ADDR_W'(4);
  assign w_slot_free = !id_valid || id_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_START;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_req       = 1'b0;
    w_load      = 1'b0;
    w_flush     = 1'b0;
    unique case (r_state)
      ST_START: w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (redirect_valid) begin
          w_pc_nxt = redirect_pc;
          w_flush  = 1'b1;
        end else begin
          w_req = w_slot_free;
          if (w_req && imem_req_ready)
            w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_flush     = 1'b1;
          w_state_nxt = imem_rsp_valid ? ST_REQ : ST_DROP;
        end else if (imem_rsp_valid) begin
          w_load      = 1'b1;
          w_pc_nxt    = w_pc4;
          w_state_nxt = ST_REQ;
        end
      end
      ST_DROP: begin
        // the in-flight word is wrong-path; only its arrival matters
        if (redirect_valid) begin
          w_pc_nxt = redirect_pc;
          w_flush  = 1'b1;
        end
        if (imem_rsp_valid)
          w_state_nxt = ST_REQ;
      end
      default: w_state_nxt = ST_START;
    endcase
  end

  assign imem_req_valid = w_req;
  assign imem_addr      = r_pc;

  if_id_reg #(
    .ADDR_W (ADDR_W)
  ) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_drain (id_ready),
    .i_inst  (imem_rsp_data),
    .i_pc4   (w_pc4),
    .o_valid (id_valid),
    .o_inst  (id_inst),
    .o_pc4   (id_pc4)
  );

  assign id_opcode = id_inst[OPCODE_MSB:OPCODE_LSB];

  a_rsp_proto: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (r_state == ST_WAIT || r_state == ST_DROP)
  );

endmodule
